uart_tx_core: RTL and testbench

Parametrised UART transmit engine that replaces the fixed 8-bit transmit state sequencer. It owns the bit timing (oversample tick counting), the data shift register, parity generation and stop-bit timing. Frame format is configurable per frame: 5..MAX_DW data bits, five parity modes, and 1, 1.5 or 2 stop bits. It sits between the TX FIFO (valid/ready) and the serial pin, driven by the shared baud-rate generator's oversample tick.

---
 rtl/uart_tx_core_pkg.sv | 55 +++++
 rtl/uart_tx_core_if.sv | 21 ++
 rtl/uart_tx_bit_timer.sv | 30 +++
 rtl/uart_tx_core.sv | 143 ++++++++++++++
 tb/tb_uart_tx_core.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_core_pkg.sv
// Shared types and helpers for the UART transmit engine.
package uart_tx_core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_core_state_e;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    EVEN  = 3'd1,
    ODD   = 3'd2,
    MARK  = 3'd3,
    SPACE = 3'd4
  } uart_parity_e;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } uart_stop_e;

  localparam int unsigned MIN_DW = 5;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                  input int unsigned max_dw);
    if (req < 4'(MIN_DW)) return 4'(MIN_DW);
    if (req > 4'(max_dw)) return 4'(max_dw);
    return req;
  endfunction

  // Codes 5..7 are reserved and fall back to no parity.
  function automatic uart_parity_e decode_parity(input logic [2:0] code);
    case (code)
      3'd1:    return EVEN;
      3'd2:    return ODD;
      3'd3:    return MARK;
      3'd4:    return SPACE;
      default: return NONE;
    endcase
  endfunction

  function automatic uart_stop_e decode_stop(input logic [1:0] code);
    case (code)
      2'd1:    return STOP_1P5;
      2'd2,
      2'd3:    return STOP_2;
      default: return STOP_1;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Payload handshake and per-frame format between the TX FIFO and the transmit engine.
interface uart_tx_core_if #(
  parameter int unsigned MAX_DW = 8
);
  logic [MAX_DW-1:0] data_i;
  logic              data_valid_i;
  logic              data_ready_o;
  logic [3:0]        data_bits_i;
  logic [2:0]        parity_mode_i;
  logic [1:0]        stop_mode_i;

  modport master (
    output data_i, data_valid_i, data_bits_i, parity_mode_i, stop_mode_i,
    input  data_ready_o
  );

  modport slave (
    input  data_i, data_valid_i, data_bits_i, parity_mode_i, stop_mode_i,
    output data_ready_o
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Counts oversample ticks and flags the tick that ends a period of period_len_i ticks.
module uart_tx_bit_timer #(
  parameter  int unsigned OSR = 16,
  localparam int unsigned LW  = $clog2(2*OSR+1)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic [LW-1:0] period_len_i,
  input  logic          clear_i,
  input  logic          tick_i,
  output logic          done_o
);

  logic [LW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == period_len_i - LW'(1));
  assign done_o = tick_i && w_last;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (tick_i) begin
      r_cnt <= w_last ? '0 : r_cnt + LW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: frame sequencing, shift register, parity and stop timing.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int unsigned MAX_DW = 8,
  parameter int unsigned OSR    = 16
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                tick_i,
  uart_tx_core_if.slave       tx_if,
  output logic                tx_o,
  output logic                busy_o,
  output uart_tx_core_state_e state_o
);

  localparam int unsigned LW = $clog2(2*OSR+1);

  uart_tx_core_state_e r_state;
  logic                r_tx;
  logic [MAX_DW-1:0]   r_shift;
  logic [3:0]          r_bit_cnt;
  logic [3:0]          r_nbits;
  uart_parity_e        r_par_mode;
  logic                r_par_bit;
  logic [LW-1:0]       r_stop_len;

  logic [3:0]          w_nbits;
  uart_parity_e        w_par_mode;
  logic                w_xor;
  logic                w_par_bit;
  logic [LW-1:0]       w_stop_len;
  logic [LW-1:0]       w_period;
  logic                w_done;

  // Frame format decode, only consumed on accept.
  always_comb begin
    w_nbits    = clamp_data_bits(tx_if.data_bits_i, MAX_DW);
    w_par_mode = decode_parity(tx_if.parity_mode_i);
    w_xor      = 1'b0;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      if (i < 32'(w_nbits)) w_xor = w_xor ^ tx_if.data_i[i];
    end
    w_par_bit = 1'b0;
    case (w_par_mode)
      EVEN:    w_par_bit = w_xor;
      ODD:     w_par_bit = ~w_xor;
      MARK:    w_par_bit = 1'b1;
      default: w_par_bit = 1'b0;
    endcase
    case (decode_stop(tx_if.stop_mode_i))
      STOP_1P5: w_stop_len = LW'(3*OSR/2);
      STOP_2:   w_stop_len = LW'(2*OSR);
      default:  w_stop_len = LW'(OSR);
    endcase
  end

  assign w_period = (r_state == STOP) ? r_stop_len : LW'(OSR);

  // Held clear in IDLE so START counts from the first tick after accept.
  uart_tx_bit_timer #(.OSR(OSR)) u_bit_timer (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .period_len_i (w_period),
    .clear_i      (r_state == IDLE),
    .tick_i       (tick_i),
    .done_o       (w_done)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_nbits    <= '0;
      r_par_mode <= NONE;
      r_par_bit  <= 1'b0;
      r_stop_len <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (tx_if.data_valid_i) begin
            r_shift    <= tx_if.data_i;
            r_bit_cnt  <= '0;
            r_nbits    <= w_nbits;
            r_par_mode <= w_par_mode;
            r_par_bit  <= w_par_bit;
            r_stop_len <= w_stop_len;
            r_state    <= START;
            r_tx       <= 1'b0;
          end
        end
        START: begin
          if (w_done) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_done) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt + 4'd1 == r_nbits) begin
              if (r_par_mode != NONE) begin
                r_state <= PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              // Next bit is bit 1 of the pre-shift value.
              r_tx <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_done) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
        STOP: begin
          if (w_done) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_if.data_ready_o = (r_state == IDLE);
  assign busy_o             = (r_state != IDLE);
  assign state_o            = r_state;
  assign tx_o               = r_tx;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core (MAX_DW=8, OSR=16) with hand-computed frames.
module tb_uart_tx_core;
  import uart_tx_core_pkg::*;

  logic                clk = 1'b0;
  logic                arst_ni;
  logic                tick_i;
  logic                tx_o;
  logic                busy_o;
  uart_tx_core_state_e state_o;

  int unsigned tick_div = 1;
  int unsigned tick_ph  = 0;
  int          n_total  = 0;
  int          n_bad    = 0;

  logic                cap_tx   [0:1399];
  logic                cap_busy [0:1399];
  logic                cap_rdy  [0:1399];
  uart_tx_core_state_e cap_st   [0:1399];

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  nb_in;
    logic [2:0]  pm;
    logic [1:0]  sm;
    int unsigned nb;
    bit          par_on;
    logic        pb;
    int unsigned total;
  } vec_t;

  uart_tx_core_if #(.MAX_DW(8)) u_if ();

  uart_tx_core #(.MAX_DW(8), .OSR(16)) dut (
    .clk_i   (clk),
    .arst_ni (arst_ni),
    .tick_i  (tick_i),
    .tx_if   (u_if),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    tick_i = 1'b0;
    forever begin
      @(negedge clk);
      tick_i  = (tick_ph == 0);
      tick_ph = (tick_ph + 1 >= tick_div) ? 0 : tick_ph + 1;
    end
  end

  // Expected line level for sample i (tick every cycle, 16 cycles per bit).
  function automatic logic exp_tx(input int unsigned i, input logic [7:0] d,
                                  input int unsigned nb, input bit par_on, input logic pb);
    if (i < 16) return 1'b0;
    if (i < 16 + 16*nb) return d[(i-16)/16];
    if (par_on && i < 32 + 16*nb) return pb;
    return 1'b1;
  endfunction

  // Offers one payload, then scrambles the inputs and records n cycles from START.
  task automatic xmit(input logic [7:0] d, input logic [3:0] nb, input logic [2:0] pm,
                      input logic [1:0] sm, input int unsigned n);
    @(negedge clk);
    n_total++;
    if (u_if.data_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_accept: got %b want 1", u_if.data_ready_o);
    end
    u_if.data_i        = d;
    u_if.data_bits_i   = nb;
    u_if.parity_mode_i = pm;
    u_if.stop_mode_i   = sm;
    u_if.data_valid_i  = 1'b1;
    @(negedge clk);
    u_if.data_valid_i  = 1'b0;
    u_if.data_i        = ~d;
    u_if.data_bits_i   = 4'd5;
    u_if.parity_mode_i = 3'd3;
    u_if.stop_mode_i   = 2'd1;
    for (int unsigned i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      cap_tx[i]   = tx_o;
      cap_busy[i] = busy_o;
      cap_rdy[i]  = u_if.data_ready_o;
      cap_st[i]   = state_o;
    end
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_o !== 1'b1 || u_if.data_ready_o !== 1'b1 || busy_o !== 1'b0 || state_o !== IDLE) begin
      n_bad++;
      $display("FAIL reset_hold: tx=%b rdy=%b busy=%b st=%0d want 1 1 0 %0d",
               tx_o, u_if.data_ready_o, busy_o, state_o, IDLE);
    end
    arst_ni = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_o !== 1'b1 || u_if.data_ready_o !== 1'b1 || busy_o !== 1'b0 || state_o !== IDLE) begin
      n_bad++;
      $display("FAIL reset_release_idle: tx=%b rdy=%b busy=%b st=%0d want 1 1 0 %0d",
               tx_o, u_if.data_ready_o, busy_o, state_o, IDLE);
    end
  endtask

  task automatic test_8n1();
    int unsigned nbusy = 0;
    xmit(8'hA5, 4'd8, 3'd0, 2'd0, 168);
    for (int unsigned s = 0; s < 21; s++) begin
      logic want;
      bit ok;
      int unsigned bi;
      want = exp_tx(8*s, 8'hA5, 8, 1'b0, 1'b0);
      ok = 1'b1;
      bi = 8*s;
      for (int unsigned k = 8*s; k < 8*s + 8; k++)
        if (ok && cap_tx[k] !== want) begin ok = 1'b0; bi = k; end
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL 8n1_tx seg %0d: sample %0d tx=%b want %b", s, bi, cap_tx[bi], want);
      end
    end
    for (int unsigned k = 0; k < 168; k++) if (cap_busy[k] === 1'b1) nbusy++;
    n_total++;
    if (nbusy != 160) begin
      n_bad++;
      $display("FAIL 8n1_busy_cycles: got %0d want 160", nbusy);
    end
    n_total++;
    if (cap_rdy[0] !== 1'b0 || cap_rdy[159] !== 1'b0 || cap_rdy[160] !== 1'b1) begin
      n_bad++;
      $display("FAIL 8n1_ready: rdy[0]=%b rdy[159]=%b rdy[160]=%b want 0 0 1",
               cap_rdy[0], cap_rdy[159], cap_rdy[160]);
    end
    n_total++;
    if (cap_st[0] !== START || cap_st[16] !== DATA || cap_st[144] !== STOP || cap_st[160] !== IDLE) begin
      n_bad++;
      $display("FAIL 8n1_states: %0d %0d %0d %0d want %0d %0d %0d %0d",
               cap_st[0], cap_st[16], cap_st[144], cap_st[160], START, DATA, STOP, IDLE);
    end
  endtask

  task automatic test_formats();
    vec_t v [6];
    // 0xC1: bit 7 set would flip the 7-bit even parity if it leaked in.
    v[0] = '{8'hC1, 4'd7,  3'd1, 2'd2, 7, 1'b1, 1'b0, 176};
    v[1] = '{8'h1F, 4'd5,  3'd2, 2'd1, 5, 1'b1, 1'b0, 136};
    v[2] = '{8'h00, 4'd8,  3'd3, 2'd0, 8, 1'b1, 1'b1, 176};
    v[3] = '{8'hFF, 4'd8,  3'd4, 2'd0, 8, 1'b1, 1'b0, 176};
    v[4] = '{8'h3C, 4'd3,  3'd6, 2'd0, 5, 1'b0, 1'b0, 112};
    v[5] = '{8'h5A, 4'd15, 3'd1, 2'd3, 8, 1'b1, 1'b0, 192};
    for (int unsigned t = 0; t < 6; t++) begin
      int unsigned pidx;
      uart_tx_core_state_e pst;
      xmit(v[t].d, v[t].nb_in, v[t].pm, v[t].sm, v[t].total + 8);
      for (int unsigned s = 0; s < (v[t].total + 8) / 8; s++) begin
        logic want;
        bit ok;
        int unsigned bi;
        want = exp_tx(8*s, v[t].d, v[t].nb, v[t].par_on, v[t].pb);
        ok = 1'b1;
        bi = 8*s;
        for (int unsigned k = 8*s; k < 8*s + 8; k++)
          if (ok && cap_tx[k] !== want) begin ok = 1'b0; bi = k; end
        n_total++;
        if (!ok) begin
          n_bad++;
          $display("FAIL fmt%0d_tx seg %0d: sample %0d tx=%b want %b", t, s, bi, cap_tx[bi], want);
        end
      end
      n_total++;
      if (cap_rdy[v[t].total - 1] !== 1'b0 || cap_rdy[v[t].total] !== 1'b1) begin
        n_bad++;
        $display("FAIL fmt%0d_frame_len: rdy[%0d]=%b rdy[%0d]=%b want 0 1", t,
                 v[t].total - 1, cap_rdy[v[t].total - 1], v[t].total, cap_rdy[v[t].total]);
      end
      pidx = 16 * (1 + v[t].nb);
      pst  = v[t].par_on ? PARITY : STOP;
      n_total++;
      if (cap_st[pidx] !== pst) begin
        n_bad++;
        $display("FAIL fmt%0d_after_data_state: got %0d want %0d", t, cap_st[pidx], pst);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned i1 = 0, d1 = 0, s2 = 0, d2 = 0;
    bit f1 = 1'b0, fd = 1'b0, got = 1'b0;
    logic [7:0] b_lo, b_mid, b_hi;
    tick_div = 4;
    repeat (8) @(negedge clk);
    u_if.data_i        = 8'h55;
    u_if.data_bits_i   = 4'd8;
    u_if.parity_mode_i = 3'd0;
    u_if.stop_mode_i   = 2'd0;
    u_if.data_valid_i  = 1'b1;
    fork
      begin
        for (int unsigned i = 0; i < 1320; i++) begin
          @(negedge clk);
          cap_tx[i] = tx_o;
          cap_st[i] = state_o;
        end
      end
      begin
        @(negedge clk);
        u_if.data_i = 8'hAA;
        for (int unsigned i = 0; i < 1300 && !got; i++) begin
          @(negedge clk);
          if (u_if.data_ready_o === 1'b1) got = 1'b1;
        end
        @(negedge clk);
        u_if.data_valid_i = 1'b0;
      end
    join
    n_total++;
    if (!got) begin
      n_bad++;
      $display("FAIL b2b_second_accept: ready never returned within 1300 cycles, want 1");
    end
    for (int unsigned i = 0; i < 1320; i++) begin
      if (!fd && cap_st[i] === DATA) begin fd = 1'b1; d1 = i; end
      if (!f1 && cap_st[i] === IDLE) begin f1 = 1'b1; i1 = i; end
    end
    n_total++;
    if (!f1 || !fd || i1 != d1 + 576) begin
      n_bad++;
      $display("FAIL b2b_frame1_len: idle_at=%0d data_at=%0d want idle_at=data_at+576", i1, d1);
    end else begin
      for (int unsigned b = 0; b < 8; b++) begin
        b_lo[b]  = cap_tx[d1 + 64*b];
        b_mid[b] = cap_tx[d1 + 64*b + 32];
        b_hi[b]  = cap_tx[d1 + 64*b + 63];
      end
      n_total++;
      if (b_lo !== 8'h55 || b_mid !== 8'h55 || b_hi !== 8'h55) begin
        n_bad++;
        $display("FAIL b2b_frame1_bits: lo=%h mid=%h hi=%h want 55", b_lo, b_mid, b_hi);
      end
      n_total++;
      if (cap_st[d1 + 511] !== DATA || cap_st[d1 + 512] !== STOP) begin
        n_bad++;
        $display("FAIL b2b_frame1_data_len: st=%0d,%0d want %0d,%0d",
                 cap_st[d1 + 511], cap_st[d1 + 512], DATA, STOP);
      end
      s2 = i1 + 1;
      n_total++;
      if (cap_st[s2] !== START) begin
        n_bad++;
        $display("FAIL b2b_idle_gap: st after idle=%0d want %0d", cap_st[s2], START);
      end
      // Ticks every 4 cycles: START spans 63 cycles after a one-cycle IDLE.
      n_total++;
      if (cap_st[s2 + 62] !== START || cap_st[s2 + 63] !== DATA) begin
        n_bad++;
        $display("FAIL b2b_frame2_start_len: st=%0d,%0d want %0d,%0d",
                 cap_st[s2 + 62], cap_st[s2 + 63], START, DATA);
      end
      d2 = s2 + 63;
      for (int unsigned b = 0; b < 8; b++) begin
        b_lo[b]  = cap_tx[d2 + 64*b];
        b_mid[b] = cap_tx[d2 + 64*b + 32];
        b_hi[b]  = cap_tx[d2 + 64*b + 63];
      end
      n_total++;
      if (b_lo !== 8'hAA || b_mid !== 8'hAA || b_hi !== 8'hAA) begin
        n_bad++;
        $display("FAIL b2b_frame2_bits: lo=%h mid=%h hi=%h want aa", b_lo, b_mid, b_hi);
      end
      n_total++;
      if (cap_st[d2 + 575] !== STOP || cap_st[d2 + 576] !== IDLE) begin
        n_bad++;
        $display("FAIL b2b_frame2_end: st=%0d,%0d want %0d,%0d",
                 cap_st[d2 + 575], cap_st[d2 + 576], STOP, IDLE);
      end
    end
    tick_div = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    xmit(8'h00, 4'd8, 3'd0, 2'd0, 70);
    n_total++;
    if (cap_tx[69] !== 1'b0 || cap_st[69] !== DATA) begin
      n_bad++;
      $display("FAIL rst_pre_bit3: tx=%b st=%0d want 0 %0d", cap_tx[69], cap_st[69], DATA);
    end
    arst_ni = 1'b0;
    #1;
    n_total++;
    if (tx_o !== 1'b1 || u_if.data_ready_o !== 1'b1 || busy_o !== 1'b0 || state_o !== IDLE) begin
      n_bad++;
      $display("FAIL rst_mid_immediate: tx=%b rdy=%b busy=%b st=%0d want 1 1 0 %0d",
               tx_o, u_if.data_ready_o, busy_o, state_o, IDLE);
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (tx_o !== 1'b1 || u_if.data_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_hold: tx=%b rdy=%b want 1 1", tx_o, u_if.data_ready_o);
    end
    arst_ni = 1'b1;
    xmit(8'h0F, 4'd8, 3'd0, 2'd0, 168);
    for (int unsigned s = 0; s < 21; s++) begin
      logic want;
      bit ok;
      int unsigned bi;
      want = exp_tx(8*s, 8'h0F, 8, 1'b0, 1'b0);
      ok = 1'b1;
      bi = 8*s;
      for (int unsigned k = 8*s; k < 8*s + 8; k++)
        if (ok && cap_tx[k] !== want) begin ok = 1'b0; bi = k; end
      n_total++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rst_after_tx seg %0d: sample %0d tx=%b want %b", s, bi, cap_tx[bi], want);
      end
    end
    n_total++;
    if (cap_rdy[159] !== 1'b0 || cap_rdy[160] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_after_len: rdy[159]=%b rdy[160]=%b want 0 1", cap_rdy[159], cap_rdy[160]);
    end
  endtask

  initial begin
    arst_ni            = 1'b0;
    u_if.data_i        = '0;
    u_if.data_valid_i  = 1'b0;
    u_if.data_bits_i   = 4'd8;
    u_if.parity_mode_i = 3'd0;
    u_if.stop_mode_i   = 2'd0;
    test_reset();
    test_8n1();
    test_formats();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
